// File: rtl/trap_csr_unit_if.sv
// Trap/CSR request and response bundle between the cause stage,
// the CSR file and the front end.
interface trap_csr_unit_if;
  logic        CS;
  logic [63:0] CAUSE;
  logic        RET_INST;
  logic [63:0] EPC_IN;
  logic [63:0] TVAL_IN;
  logic        CSR_WE;
  logic [11:0] CSR_ADDR;
  logic [63:0] CSR_WDATA;
  logic [63:0] CSR_RDATA;
  logic [1:0]  PRIVILEGE;
  logic        FLUSH;
  logic        REDIRECT_VALID;
  logic [63:0] REDIRECT_PC;
  logic        BUSY;

  modport master (
    output CS, CAUSE, RET_INST, EPC_IN, TVAL_IN,
    output CSR_WE, CSR_ADDR, CSR_WDATA,
    input  CSR_RDATA, PRIVILEGE, FLUSH,
    input  REDIRECT_VALID, REDIRECT_PC, BUSY
  );

  modport slave (
    input  CS, CAUSE, RET_INST, EPC_IN, TVAL_IN,
    input  CSR_WE, CSR_ADDR, CSR_WDATA,
    output CSR_RDATA, PRIVILEGE, FLUSH,
    output REDIRECT_VALID, REDIRECT_PC, BUSY
  );
endinterface

// File: rtl/trap_csr_unit.sv
// Machine-mode trap entry / MRET sequencer with its CSR file,
// flush + redirect strobe and front-end drain window.
module trap_csr_unit #(
  parameter int          DRAIN_CYCLES = 3,
  parameter logic [63:0] MTVEC_RESET  = 64'h0
) (
  input logic CLK,
  input logic RESET,
  trap_csr_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    DRAIN
  } state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        mie, mpie;
  logic [1:0]  mpp, priv;
  logic [63:0] mtvec, mepc, mcause, mtval;
  logic [63:0] target, target_n;
  logic [63:0] base, mstatus;
  logic        accept, trap, mret;
  logic        csr_wr, vec_trap;

  assign mstatus = {51'b0, mpp, 3'b0, mpie,
                    3'b0, mie, 3'b0};

  assign accept   = (state == IDLE) && bus.CS;
  assign trap     = accept && !bus.RET_INST;
  assign mret     = accept && bus.RET_INST;
  assign csr_wr   = (state == IDLE) && bus.CSR_WE
                    && !bus.CS;
  assign base     = {mtvec[63:2], 2'b00};
  assign vec_trap = trap && (mtvec[1:0] == 2'd1)
                    && bus.CAUSE[63];

  always_comb begin
    target_n = base;
    unique case (1'b1)
      mret:     target_n = mepc;
      vec_trap: target_n = base
                  + {bus.CAUSE[61:0], 2'b00};
      default:  target_n = base;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) state_n = REDIRECT;
      end
      REDIRECT: begin
        state_n = DRAIN;
        cnt_n   = 4'(DRAIN_CYCLES);
      end
      DRAIN: begin
        if (cnt <= 4'd1) begin
          state_n = IDLE;
          cnt_n   = 4'd0;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  // Trap/MRET commits take priority; CSR writes only land when neither fires.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      mie    <= 1'b0;
      mpie   <= 1'b0;
      mpp    <= 2'd0;
      priv   <= 2'd3;
      mtvec  <= MTVEC_RESET;
      mepc   <= 64'h0;
      mcause <= 64'h0;
      mtval  <= 64'h0;
      target <= 64'h0;
    end else begin
      if (accept) target <= target_n;
      if (trap) begin
        mepc   <= bus.EPC_IN & ~64'h3;
        mcause <= bus.CAUSE;
        mtval  <= bus.TVAL_IN;
        mpie   <= mie;
        mie    <= 1'b0;
        mpp    <= priv;
        priv   <= 2'd3;
      end else if (mret) begin
        priv <= mpp;
        mie  <= mpie;
        mpie <= 1'b1;
        mpp  <= 2'd0;
      end else if (csr_wr) begin
        case (bus.CSR_ADDR)
          12'h300: begin
            mie  <= bus.CSR_WDATA[3];
            mpie <= bus.CSR_WDATA[7];
            mpp  <= bus.CSR_WDATA[12:11];
          end
          12'h305: mtvec <= bus.CSR_WDATA[1]
                      ? {bus.CSR_WDATA[63:2], 2'b00}
                      : bus.CSR_WDATA;
          12'h341: mepc <= bus.CSR_WDATA & ~64'h3;
          12'h342: mcause <= bus.CSR_WDATA;
          12'h343: mtval <= bus.CSR_WDATA;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.CSR_RDATA = 64'h0;
    case (bus.CSR_ADDR)
      12'h300: bus.CSR_RDATA = mstatus;
      12'h305: bus.CSR_RDATA = mtvec;
      12'h341: bus.CSR_RDATA = mepc;
      12'h342: bus.CSR_RDATA = mcause;
      12'h343: bus.CSR_RDATA = mtval;
      default: bus.CSR_RDATA = 64'h0;
    endcase
  end

  assign bus.PRIVILEGE      = priv;
  assign bus.FLUSH          = (state == REDIRECT);
  assign bus.REDIRECT_VALID = (state == REDIRECT);
  assign bus.REDIRECT_PC    = (state == REDIRECT)
                              ? target : 64'h0;
  assign bus.BUSY           = (state != IDLE) || accept;

endmodule

// File: tb/tb_trap_csr_unit.sv
// Directed bench for trap_csr_unit: trap entry, vectoring,
// MRET, CS during drain, CSR write priority and reset abort.
module tb_trap_csr_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  trap_csr_unit_if bus ();

  trap_csr_unit #(
    .DRAIN_CYCLES(3),
    .MTVEC_RESET (64'h0)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a,
                    output logic [63:0] d);
    bus.CSR_ADDR = a;
    #1;
    d = bus.CSR_RDATA;
  endtask

  task automatic chk_csr(input string tag,
                         input logic [11:0] a,
                         input logic [63:0] exp);
    logic [63:0] d;
    rd(a, d);
    chk(tag, d, exp);
  endtask

  task automatic csr_wr(input logic [11:0] a,
                        input logic [63:0] d);
    bus.CSR_WE    = 1'b1;
    bus.CSR_ADDR  = a;
    bus.CSR_WDATA = d;
    step();
    bus.CSR_WE = 1'b0;
  endtask

  task automatic fire(input string tag,
                      input logic ret,
                      input logic [63:0] cause,
                      input logic [63:0] epc,
                      input logic [63:0] tval,
                      input logic [63:0] exp_pc);
    int n;
    bus.CS       = 1'b1;
    bus.RET_INST = ret;
    bus.CAUSE    = cause;
    bus.EPC_IN   = epc;
    bus.TVAL_IN  = tval;
    #1;
    chk({tag, "_busy_t"}, 64'(bus.BUSY), 64'd1);
    step();
    bus.CS       = 1'b0;
    bus.RET_INST = 1'b0;
    chk({tag, "_flush"}, 64'(bus.FLUSH), 64'd1);
    chk({tag, "_rv"}, 64'(bus.REDIRECT_VALID), 64'd1);
    chk({tag, "_pc"}, bus.REDIRECT_PC, exp_pc);
    n = 0;
    while (bus.BUSY && n < 20) begin
      n++;
      step();
    end
    chk({tag, "_busy_len"}, 64'(n), 64'd4);
  endtask

  initial begin
    int pulses;
    int first_at;
    int second_at;
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.CS       = 1'b0;
    bus.RET_INST = 1'b0;
    bus.CAUSE    = '0;
    bus.EPC_IN   = '0;
    bus.TVAL_IN  = '0;
    bus.CSR_WE   = 1'b0;
    bus.CSR_ADDR = '0;
    bus.CSR_WDATA = '0;
    step();
    step();
    rst = 1'b0;

    chk("rst_priv", 64'(bus.PRIVILEGE), 64'd3);
    chk("rst_flush", 64'(bus.FLUSH), 64'd0);
    chk("rst_rv", 64'(bus.REDIRECT_VALID), 64'd0);
    chk("rst_pc", bus.REDIRECT_PC, 64'd0);
    chk("rst_busy", 64'(bus.BUSY), 64'd0);
    chk_csr("rst_mstatus", 12'h300, 64'h0);
    chk_csr("rst_mtvec", 12'h305, 64'h0);
    chk_csr("rst_mcause", 12'h342, 64'h0);

    // drop to U-mode with MRET (MPP=0, mepc=0)
    fire("mret0", 1'b1, 64'd9, 64'h0, 64'h0, 64'h0);
    chk("mret0_priv", 64'(bus.PRIVILEGE), 64'd0);
    chk_csr("mret0_mstatus", 12'h300, 64'h80);
    chk_csr("mret0_mcause", 12'h342, 64'h0);

    csr_wr(12'h305, 64'h8000_0000);
    fire("trap1", 1'b0, 64'd2, 64'h1000, 64'hdead,
         64'h8000_0000);
    chk_csr("trap1_mepc", 12'h341, 64'h1000);
    chk_csr("trap1_mcause", 12'h342, 64'd2);
    chk_csr("trap1_mtval", 12'h343, 64'hdead);
    chk_csr("trap1_mstatus", 12'h300, 64'h0);
    chk("trap1_priv", 64'(bus.PRIVILEGE), 64'd3);

    csr_wr(12'h305, 64'h8000_0001);
    chk_csr("mtvec_vec", 12'h305, 64'h8000_0001);
    fire("vec_irq", 1'b0, {1'b1, 63'd7}, 64'h1100,
         64'h0, 64'h8000_001C);
    chk_csr("vec_mcause", 12'h342, {1'b1, 63'd7});
    fire("vec_exc", 1'b0, 64'd5, 64'h1200, 64'h0,
         64'h8000_0000);
    csr_wr(12'h305, 64'h8000_0003);
    chk_csr("mtvec_mode3", 12'h305, 64'h8000_0000);

    csr_wr(12'h300, 64'h8);
    chk_csr("mie_set", 12'h300, 64'h8);
    fire("trap_mie", 1'b0, 64'd11, 64'h1300, 64'h0,
         64'h8000_0000);
    chk_csr("trap_mie_ms", 12'h300, 64'h1880);
    csr_wr(12'h300, 64'h80);
    csr_wr(12'h341, 64'h2004);
    fire("mret1", 1'b1, 64'd4, 64'h0, 64'h0, 64'h2004);
    chk("mret1_priv", 64'(bus.PRIVILEGE), 64'd0);
    chk_csr("mret1_ms", 12'h300, 64'h88);
    chk_csr("mret1_mcause", 12'h342, 64'd11);
    chk_csr("mret1_mepc", 12'h341, 64'h2004);

    // CS held for six cycles: second accept only after drain
    pulses    = 0;
    first_at  = -1;
    second_at = -1;
    bus.CAUSE  = 64'd3;
    bus.EPC_IN = 64'h5000;
    for (int i = 0; i < 12; i++) begin
      bus.CS = (i < 6);
      #1;
      if (bus.REDIRECT_VALID) begin
        pulses++;
        if (first_at < 0) first_at = i;
        else second_at = i;
      end
      step();
    end
    bus.CS = 1'b0;
    chk("hold_pulses", 64'(pulses), 64'd2);
    chk("hold_first", 64'(first_at), 64'd1);
    chk("hold_second", 64'(second_at), 64'd6);

    // write collides with accepted trap, then held through drain
    bus.CSR_WE    = 1'b1;
    bus.CSR_ADDR  = 12'h341;
    bus.CSR_WDATA = 64'h3003;
    fire("wr_col", 1'b0, 64'd6, 64'h4006, 64'h77,
         64'h8000_0000);
    bus.CSR_WE = 1'b0;
    chk_csr("wr_col_mepc", 12'h341, 64'h4004);
    bus.CSR_WE    = 1'b1;
    bus.CSR_ADDR  = 12'h341;
    bus.CSR_WDATA = 64'h3003;
    #1;
    chk("rdw_old", bus.CSR_RDATA, 64'h4004);
    step();
    bus.CSR_WE = 1'b0;
    chk_csr("rdw_new", 12'h341, 64'h3000);
    csr_wr(12'h344, 64'hff);
    chk_csr("unmapped", 12'h344, 64'h0);
    chk_csr("unmapped_mtval", 12'h343, 64'h77);

    // reset in the redirect cycle aborts everything
    bus.CS     = 1'b1;
    bus.CAUSE  = 64'd3;
    bus.EPC_IN = 64'h6000;
    step();
    bus.CS = 1'b0;
    chk("pre_rst_flush", 64'(bus.FLUSH), 64'd1);
    rst = 1'b1;
    step();
    chk("abort_flush", 64'(bus.FLUSH), 64'd0);
    chk("abort_rv", 64'(bus.REDIRECT_VALID), 64'd0);
    chk("abort_busy", 64'(bus.BUSY), 64'd0);
    chk("abort_priv", 64'(bus.PRIVILEGE), 64'd3);
    chk_csr("abort_mcause", 12'h342, 64'h0);
    chk_csr("abort_mepc", 12'h341, 64'h0);
    rst = 1'b0;
    step();
    chk("post_rst_busy", 64'(bus.BUSY), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_csr_unit.md
Name: trap_csr_unit

Overview:
- Machine-mode trap sequencer directly downstream of the trap cause/select stage.
- Consumes the registered trap strobe CS, the 64-bit CAUSE and RET_INST.
- Owns mstatus/mtvec/mepc/mcause/mtval and the current privilege level. Commits trap entry or MRET, issues a one-cycle pipeline flush and PC redirect, then holds the front end busy for a drain window.

Parameters:
DRAIN_CYCLES, 3, cycles BUSY stays high after the redirect cycle (1..15).
MTVEC_RESET, 64'h0, reset value of mtvec.

Ports:
CLK  input  1  clock, all state updates on posedge.
RESET  input  1  synchronous, active-high reset.
CS  input  1  trap/return strobe from the cause stage.
CAUSE  input  64  trap cause; bit 63 = interrupt, bits 62:0 = code.
RET_INST  input  1  qualifies CS as MRET rather than trap.
EPC_IN  input  64  PC of the trapping or returning instruction.
TVAL_IN  input  64  faulting address or instruction bits.
CSR_WE  input  1  software CSR write enable.
CSR_ADDR  input  12  CSR address for read and write.
CSR_WDATA  input  64  CSR write data.
CSR_RDATA  output  64  combinational read of CSR_ADDR; 0 for unmapped addresses.
PRIVILEGE  output  2  current privilege (0=U, 1=S, 3=M).
FLUSH  output  1  one-cycle pipeline flush.
REDIRECT_VALID  output  1  one-cycle PC redirect strobe.
REDIRECT_PC  output  64  redirect target; valid only with REDIRECT_VALID.
BUSY  output  1  high from accept through the end of the drain; front end stalls.

Behaviour:
- Reset: PRIVILEGE=3, FLUSH=0, REDIRECT_VALID=0, REDIRECT_PC=0, BUSY=0, mstatus=0, mtvec=MTVEC_RESET, mepc=0, mcause=0, mtval=0, state=IDLE, drain counter=0.
- CSR map:
  - 0x300 mstatus: only MIE[3], MPIE[7], MPP[12:11] are stored; all other bits read 0.
  - 0x305 mtvec.
  - 0x341 mepc: bits [1:0] always 0.
  - 0x342 mcause.
  - 0x343 mtval.
- States: IDLE, REDIRECT, DRAIN.
- IDLE, CS=1, RET_INST=0 (trap entry), committed at the edge ending cycle T:
  - mepc<={EPC_IN[63:2],2'b00}; mcause<=CAUSE; mtval<=TVAL_IN.
  - MPIE<=MIE; MIE<=0; MPP<=PRIVILEGE; PRIVILEGE<=3.
  - Target: if mtvec[1:0]==1 and CAUSE[63]==1, {mtvec[63:2],2'b00}+4*CAUSE[62:0] (truncate to 64 bits); otherwise {mtvec[63:2],2'b00}. Computed from pre-update mtvec.
  - state<=REDIRECT.
- IDLE, CS=1, RET_INST=1 (MRET):
  - Target = current mepc.
  - PRIVILEGE<=MPP; MIE<=MPIE; MPIE<=1; MPP<=0.
  - CAUSE is ignored; mepc/mcause/mtval unchanged.
  - state<=REDIRECT.
- REDIRECT (cycle T+1):
  - FLUSH=1, REDIRECT_VALID=1, REDIRECT_PC=target, BUSY=1.
  - Load drain counter with DRAIN_CYCLES; state<=DRAIN.
- DRAIN:
  - BUSY=1, FLUSH=0, REDIRECT_VALID=0.
  - Counter decrements each cycle; at 1 → IDLE. BUSY is high for exactly DRAIN_CYCLES cycles after T+1.
- BUSY is also driven high combinationally in cycle T when a CS is accepted.
- CS arriving in REDIRECT or DRAIN is ignored, not queued. If CS is still high on the first IDLE cycle, it is a new accept.
- CSR writes:
  - Take effect at the edge, IDLE only.
  - Dropped in REDIRECT/DRAIN.
  - Dropped in a cycle where a CS is accepted; trap/MRET updates win.
- Writes to unmapped addresses are ignored.
- A CSR_RDATA read in the same cycle as a write returns the old value.
- A write to mtvec with [1:0]=2 or 3 stores [1:0]=0.
- RESET asserted in any state returns all outputs to reset values on the next edge and aborts any redirect or drain in progress; no partial CSR update survives.

Test Plan:
- Reset, then PRIVILEGE=0 via MRET with MPP=0 set; EPC_IN=0x1000, CAUSE=2, mtvec=0x8000_0000, CS pulse → next cycle FLUSH=REDIRECT_VALID=1, REDIRECT_PC=0x8000_0000; mepc=0x1000, mcause=2, MPP=0, PRIVILEGE=3; BUSY high for 1+1+3 cycles.
- mtvec=0x8000_0001 (vectored), CAUSE={1'b1,63'd7} → REDIRECT_PC=0x8000_001C. CAUSE=5 (exception) with the same mtvec → 0x8000_0000.
- MIE=1 then trap → MIE=0, MPIE=1. Then CS+RET_INST with mepc=0x2004, MPP=0 → REDIRECT_PC=0x2004, PRIVILEGE=0, MIE=1, MPIE=1, MPP=0; mcause unchanged.
- CS held high 6 cycles with DRAIN_CYCLES=3 → accepts in cycle 0 and cycle 5 only; exactly two REDIRECT_VALID pulses.
- CSR_WE to mepc (0x341, data 0x3003) in the same cycle as an accepted trap → mepc=EPC_IN-aligned, not 0x3003. The same write in IDLE alone → reads 0x3000.
- RESET asserted in REDIRECT cycle → next cycle FLUSH=0, BUSY=0, PRIVILEGE=3, mcause=0, state IDLE.
